// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    JMP = 2'd2,
    EXC = 2'd3
  } redir_src_e;

  // Instruction word and its address as handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] addr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_select.sv
// Priority mux for the redirect target: exception > jump > taken branch.
module npc_select
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic            exc_i,
  input  logic            jump_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            redir_o,
  output logic [XLEN-1:0] target_o
);

  redir_src_e src;

  always_comb begin
    src = SEQ;
    if (exc_i) begin
      src = EXC;
    end else if (jump_i) begin
      src = JMP;
    end else if (br_taken_i) begin
      src = BR;
    end
  end

  // SEQ never reaches the PC through this path; its target is a don't-care zero.
  always_comb begin
    target_o = '0;
    unique case (src)
      EXC: target_o = word_align(EXC_VECTOR);
      JMP: target_o = word_align(jump_target_i);
      BR:  target_o = word_align(br_target_i);
      SEQ: target_o = '0;
    endcase
  end

  assign redir_o = (src != SEQ);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the imem handshake and
// hands fetched words to decode through a one-entry skid register.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            exc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] epc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  fetch_pkt_t      dec_q, dec_d;
  logic            inst_valid_q, inst_valid_d;
  logic            kill_q, kill_d;

  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] pc_inc;

  npc_select #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_select (
    .exc_i         (exc),
    .jump_i        (jump),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jump_target_i (jump_target),
    .redir_o       (redir),
    .target_o      (redir_target)
  );

  assign pc_inc = pc_q + XLEN'(4);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      skid_q       <= '0;
      dec_q        <= '0;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      skid_q       <= skid_d;
      dec_q        <= dec_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    skid_d       = skid_q;
    dec_d        = dec_q;
    inst_valid_d = inst_valid_q;
    kill_d       = kill_q;
    imem_req     = 1'b0;

    if (exc) begin
      epc_d = dec_q.addr;
    end

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = !stall;
        if (redir) begin
          pc_d         = redir_target;
          inst_valid_d = 1'b0;
        end else if (!stall) begin
          if (imem_ack) begin
            dec_d        = '{word: imem_rdata, addr: pc_q};
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
          end else begin
            inst_valid_d = 1'b0;
            state_d      = WAIT;
          end
        end
      end

      // A killed request still has to drain its ack before fetching again.
      WAIT: begin
        imem_req = 1'b1;
        if (redir) begin
          pc_d         = redir_target;
          inst_valid_d = 1'b0;
          if (imem_ack) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else if (!stall) begin
            dec_d        = '{word: imem_rdata, addr: pc_q};
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
            state_d      = FETCH;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (!stall) begin
          inst_valid_d = 1'b0;
        end
      end

      // pc still addresses the skid word, so it advances only on release.
      HOLD: begin
        if (redir) begin
          pc_d         = redir_target;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!stall) begin
          dec_d        = '{word: skid_q, addr: pc_q};
          inst_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = FETCH;
        end
      end
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = dec_q.word;
  assign inst_pc    = dec_q.addr;
  assign inst_valid = inst_valid_q;
  assign epc        = epc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle vector bench for fetch_sequencer with a small expectation queue.
module tb_fetch_sequencer;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [31:0] epc;

  fetch_sequencer dut (
    .clk         (clk),
    .clrn        (clrn),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .exc         (exc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .epc         (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, stall, br_taken, jump, exc, imem_ack}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_iv;
    logic [31:0] e_epc;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;

  vec_t vecs[$];
  vec_t hand[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; jump = 1'b0; exc = 1'b0; imem_ack = 1'b0;
    br_target = Z; jump_target = Z; imem_rdata = Z;
  endtask

  task automatic do_reset();
    idle_inputs();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #2 clrn = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    stall       = v.ctl[4];
    br_taken    = v.ctl[3];
    jump        = v.ctl[2];
    exc         = v.ctl[1];
    imem_ack    = v.ctl[0];
    br_target   = v.bt;
    jump_target = v.jt;
    imem_rdata  = v.rd;
    @(negedge clk);
    check("imem_req", idx, 32'(imem_req), 32'(v.e_req));
    check("imem_addr", idx, imem_addr, v.e_addr);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc", idx, pc, e.e_pc);
    check("inst", idx, inst, e.e_inst);
    check("inst_pc", idx, inst_pc, e.e_ipc);
    check("inst_valid", idx, 32'(inst_valid), 32'(e.e_iv));
    check("epc", idx, epc, e.e_epc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clrn = 1'b0;

    // Zero-wait memory from reset
    vecs.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hA000_0000, 1'b1, Z, 32'h4, 32'hA000_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hA000_0004, 1'b1, 32'h4, 32'h8, 32'hA000_0004, 32'h4, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hA000_0008, 1'b1, 32'h8, 32'hC, 32'hA000_0008, 32'h8, 1'b1, Z});
    // Delayed ack with stall during WAIT, then HOLD release
    vecs.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hB000_0000, 1'b1, Z, 32'h4, 32'hB000_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000000, Z, Z, Z, 1'b1, 32'h4, 32'h4, 32'hB000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b010000, Z, Z, Z, 1'b1, 32'h4, 32'h4, 32'hB000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b010001, Z, Z, 32'hB000_0004, 1'b1, 32'h4, 32'h4, 32'hB000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b010000, Z, Z, Z, 1'b0, 32'h4, 32'h4, 32'hB000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b000000, Z, Z, Z, 1'b0, 32'h4, 32'h8, 32'hB000_0004, 32'h4, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hB000_0008, 1'b1, 32'h8, 32'hC, 32'hB000_0008, 32'h8, 1'b1, Z});
    vecs.push_back('{6'b010000, Z, Z, Z, 1'b0, 32'hC, 32'hC, 32'hB000_0008, 32'h8, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hB000_000C, 1'b1, 32'hC, 32'h10, 32'hB000_000C, 32'hC, 1'b1, Z});
    // Branch while WAIT outstanding, then a double redirect while killed
    vecs.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hC000_0000, 1'b1, Z, 32'h4, 32'hC000_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000000, Z, Z, Z, 1'b1, 32'h4, 32'h4, 32'hC000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b001000, 32'h40, Z, Z, 1'b1, 32'h4, 32'h40, 32'hC000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hDEAD_BEEF, 1'b1, 32'h40, 32'h40, 32'hC000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hC000_0040, 1'b1, 32'h40, 32'h44, 32'hC000_0040, 32'h40, 1'b1, Z});
    vecs.push_back('{6'b000000, Z, Z, Z, 1'b1, 32'h44, 32'h44, 32'hC000_0040, 32'h40, 1'b0, Z});
    vecs.push_back('{6'b000100, Z, 32'h80, Z, 1'b1, 32'h44, 32'h80, 32'hC000_0040, 32'h40, 1'b0, Z});
    vecs.push_back('{6'b001000, 32'h93, Z, Z, 1'b1, 32'h80, 32'h90, 32'hC000_0040, 32'h40, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hDEAD_BEEF, 1'b1, 32'h90, 32'h90, 32'hC000_0040, 32'h40, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hC000_0090, 1'b1, 32'h90, 32'h94, 32'hC000_0090, 32'h90, 1'b1, Z});
    // Simultaneous exc/jump/branch at inst_pc 0x10, then jump beats branch under stall
    vecs.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0000, 1'b1, Z, 32'h4, 32'hD000_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0004, 1'b1, 32'h4, 32'h8, 32'hD000_0004, 32'h4, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0008, 1'b1, 32'h8, 32'hC, 32'hD000_0008, 32'h8, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_000C, 1'b1, 32'hC, 32'h10, 32'hD000_000C, 32'hC, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0010, 1'b1, 32'h10, 32'h14, 32'hD000_0010, 32'h10, 1'b1, Z});
    vecs.push_back('{6'b001111, 32'h300, 32'h200, 32'h0BAD_0BAD, 1'b1, 32'h14, 32'h8000_0180, 32'hD000_0010, 32'h10, 1'b0, 32'h10});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0180, 1'b1, 32'h8000_0180, 32'h8000_0184, 32'hD000_0180, 32'h8000_0180, 1'b1, 32'h10});
    vecs.push_back('{6'b011100, 32'h300, 32'h205, Z, 1'b0, 32'h8000_0184, 32'h204, 32'hD000_0180, 32'h8000_0180, 1'b0, 32'h10});
    vecs.push_back('{6'b000001, Z, Z, 32'hD000_0204, 1'b1, 32'h204, 32'h208, 32'hD000_0204, 32'h204, 1'b1, 32'h10});
    // Jump to 0xFFFF_FFFE wraps; branch out of HOLD discards the skid word
    vecs.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hE000_0000, 1'b1, Z, 32'h4, 32'hE000_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000101, Z, 32'hFFFF_FFFE, 32'h0BAD_0BAD, 1'b1, 32'h4, 32'hFFFF_FFFC, 32'hE000_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hE000_FFFC, 1'b1, 32'hFFFF_FFFC, Z, 32'hE000_FFFC, 32'hFFFF_FFFC, 1'b1, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hE100_0000, 1'b1, Z, 32'h4, 32'hE100_0000, Z, 1'b1, Z});
    vecs.push_back('{6'b000000, Z, Z, Z, 1'b1, 32'h4, 32'h4, 32'hE100_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b010001, Z, Z, 32'hE100_0004, 1'b1, 32'h4, 32'h4, 32'hE100_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b011000, 32'h100, Z, Z, 1'b0, 32'h4, 32'h100, 32'hE100_0000, Z, 1'b0, Z});
    vecs.push_back('{6'b000001, Z, Z, 32'hE100_0100, 1'b1, 32'h100, 32'h104, 32'hE100_0100, 32'h100, 1'b1, Z});

    foreach (vecs[i]) begin
      if (vecs[i].ctl[5]) do_reset();
      apply(vecs[i], i);
    end

    // Reset asserted mid-WAIT, then a stale ack arriving in BOOT
    hand.push_back('{6'b100000, Z, Z, Z, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    hand.push_back('{6'b000001, Z, Z, 32'hF000_0000, 1'b1, Z, 32'h4, 32'hF000_0000, Z, 1'b1, Z});
    hand.push_back('{6'b000001, Z, Z, 32'hF000_0004, 1'b1, 32'h4, 32'h8, 32'hF000_0004, 32'h4, 1'b1, Z});
    hand.push_back('{6'b000010, Z, Z, Z, 1'b1, 32'h8, 32'h8000_0180, 32'hF000_0004, 32'h4, 1'b0, 32'h4});
    hand.push_back('{6'b000000, Z, Z, Z, 1'b1, 32'h8000_0180, 32'h8000_0180, 32'hF000_0004, 32'h4, 1'b0, 32'h4});
    hand.push_back('{6'b000001, Z, Z, 32'hDEAD_BEEF, 1'b0, Z, Z, Z, Z, 1'b0, Z});
    hand.push_back('{6'b000001, Z, Z, 32'hF000_0000, 1'b1, Z, 32'h4, 32'hF000_0000, Z, 1'b1, Z});

    do_reset();
    for (int i = 0; i < 5; i++) apply(hand[i], 100 + i);
    #2 clrn = 1'b0;
    #1;
    check("rst_req", 200, 32'(imem_req), 32'h0);
    check("rst_addr", 200, imem_addr, 32'h0);
    check("rst_pc", 200, pc, 32'h0);
    check("rst_inst", 200, inst, 32'h0);
    check("rst_inst_pc", 200, inst_pc, 32'h0);
    check("rst_inst_valid", 200, 32'(inst_valid), 32'h0);
    check("rst_epc", 200, epc, 32'h0);
    @(posedge clk);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1 clrn = 1'b1;
    for (int i = 5; i < 7; i++) apply(hand[i], 100 + i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory handshake. It selects the next PC from sequential, branch, jump and exception sources, and delivers fetched instructions to decode with a stall/hold mechanism. It sits between the PC/next-PC datapath and decode, and is the only writer of `pc`.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VECTOR`, 32'h8000_0180, redirect target on exception.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `stall`  in  1  decode cannot accept a new instruction at the next edge.
- `br_taken`  in  1  branch resolved taken this cycle.
- `br_target`  in  32  branch target.
- `jump`  in  1  jump (J/JAL/JR) this cycle.
- `jump_target`  in  32  jump target.
- `exc`  in  1  exception raised on the instruction in decode.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `pc`  out  32  address of the next fetch.
- `inst`  out  32  instruction presented to decode.
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst` is live.
- `epc`  out  32  `inst_pc` captured on exception.

## Operation
- States:
  - BOOT: reset state. `imem_req`=0, `imem_ack` ignored. Next state is FETCH unconditionally.
  - FETCH: `imem_req` = !`stall`. If ack, deliver; otherwise go to WAIT.
  - WAIT: `imem_req`=1, with `imem_addr` stable regardless of `stall`. On ack with !`stall`, deliver and go to FETCH. On ack with `stall`, capture into the skid register and go to HOLD.
  - HOLD: `imem_req`=0. When `stall`=0, present the skid contents (`inst_valid`=1) and go to FETCH.
- Deliver means: `inst`<=`imem_rdata`, `inst_pc`<=`pc`, `inst_valid`<=1, `pc`<=`pc`+4.
- When FETCH issues no request because of `stall`, `inst`, `inst_pc` and `inst_valid` hold.
- `inst_valid` drops to 0 after a cycle in which decode accepts (`stall`=0) and no new instruction is delivered.
- Redirect: `redir` = `exc` | `jump` | `br_taken`.
  - Target priority is `exc` (EXC_VECTOR) > `jump` > `br_taken`.
  - Targets have bits [1:0] forced to 0.
  - A redirect overrides `stall` in the cycle it is asserted.
- Redirect effects by state:
  - FETCH (including a same-cycle ack): `pc`<=target, `inst_valid`<=0, any acked data is discarded, state stays FETCH.
  - WAIT: `pc`<=target and `kill`<=1; `inst_valid`<=0. When the ack arrives, its data is discarded, `kill`<=0, and state goes to FETCH. If a second redirect arrives while `kill`=1, the latest target wins.
  - HOLD: the skid contents are discarded, `pc`<=target, state goes to FETCH.
- On `exc`: `epc`<=`inst_pc`.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset (async, `clrn`=0): state=BOOT, `pc`=RESET_VECTOR, `inst`=0, `inst_pc`=0, `inst_valid`=0, `epc`=0, `kill`=0, skid=0, `imem_req`=0.
- Reset mid-transaction abandons any outstanding request. A late ack is ignored in BOOT.
- `imem_req` and `imem_addr` are combinational from state, `pc` and `stall`. All other outputs are registered.
- Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle, with first `inst_valid` on the second edge after reset release.
- Each memory wait cycle adds one cycle of latency. A redirect costs at least one bubble.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (BOOT, FETCH, WAIT, HOLD);
  - the default RESET_VECTOR and EXC_VECTOR constants;
  - the 2-bit redirect-source encoding (SEQ, BR, JMP, EXC).
- Sub-module `npc_select` is a combinational priority mux that produces the redirect target and `redir`. Everything else lives in the top level.

## Test plan
- Reset release with zero-wait memory and all controls idle:
  - `imem_addr` follows 0, 4, 8.
  - `inst_valid`=1 from the second edge on.
  - `inst_pc` lags `pc` by 4.
- Ack delayed 3 cycles with `stall` pulsed high during WAIT:
  - `imem_addr` stays stable until ack.
  - State goes WAIT→HOLD, with the previous `inst` held.
  - After `stall` drops, the new word appears with `inst_pc`=0x4.
- `br_taken`=1, `br_target`=0x40 while WAIT is outstanding:
  - The returning word is discarded.
  - The next `imem_addr` is 0x40.
  - `inst_valid`=0 for at least one cycle.
- `exc`, `jump` and `br_taken` asserted in the same cycle with `inst_pc`=0x10:
  - `pc`=0x8000_0180.
  - `epc`=0x10.
- `jump_target`=0xFFFF_FFFE with zero-wait memory:
  - `imem_addr`=0xFFFF_FFFC, then wraps to 0x0.
- `clrn` pulsed low mid-WAIT, then a stale ack:
  - All outputs take their reset values immediately.
  - The stale ack is ignored.
  - Fetch restarts at RESET_VECTOR.
